// File: rtl/tp_pkg.sv
// Shared types and constants for the test-pattern generator.
package tp_pkg;

  // Pattern select; codes 5..7 are reserved and render black.
  typedef enum logic [2:0] {
    SOLID   = 3'd0,
    BARS    = 3'd1,
    HRAMP   = 3'd2,
    CHECKER = 3'd3,
    MOVING  = 3'd4
  } tp_mode_t;

  // Colour-bar table, one {R,G,B} on/off triple per bar, left to right.
  localparam logic [2:0] BAR_RGB [8] = '{
    3'b111,  // white
    3'b110,  // yellow
    3'b011,  // cyan
    3'b010,  // green
    3'b101,  // magenta
    3'b100,  // red
    3'b001,  // blue
    3'b000   // black
  };

  // VGA 640x480@60 default raster.
  localparam int VGA_HACT = 640;
  localparam int VGA_HFP  = 16;
  localparam int VGA_HSP  = 96;
  localparam int VGA_HBP  = 48;
  localparam int VGA_VACT = 480;
  localparam int VGA_VFP  = 10;
  localparam int VGA_VSP  = 2;
  localparam int VGA_VBP  = 33;

endpackage

// File: rtl/tp_pattern_gen_if.sv
// Video output bundle: syncs, data valid, start of frame and RGB data.
interface tp_pattern_gen_if #(
  parameter int DW = 8
);
  logic          vsync_o;
  logic          hsync_o;
  logic          dval_o;
  logic          sof_o;
  logic [DW-1:0] rdata_o;
  logic [DW-1:0] gdata_o;
  logic [DW-1:0] bdata_o;

  modport master (output vsync_o, hsync_o, dval_o, sof_o, rdata_o, gdata_o, bdata_o);
  modport slave  (input  vsync_o, hsync_o, dval_o, sof_o, rdata_o, gdata_o, bdata_o);
endinterface

// File: rtl/tp_timing.sv
// Raster counters plus sync/active decode, x/y position and frame counter.
module tp_timing
  import tp_pkg::*;
#(
  parameter int HACT = VGA_HACT,
  parameter int HFP  = VGA_HFP,
  parameter int HSP  = VGA_HSP,
  parameter int HBP  = VGA_HBP,
  parameter int VACT = VGA_VACT,
  parameter int VFP  = VGA_VFP,
  parameter int VSP  = VGA_VSP,
  parameter int VBP  = VGA_VBP,
  parameter int DW   = 8,
  localparam int HTOTAL = HSP + HBP + HACT + HFP,
  localparam int VTOTAL = VSP + VBP + VACT + VFP,
  localparam int HW     = $clog2(HTOTAL),
  localparam int VW     = $clog2(VTOTAL)
) (
  input  logic          px_clk,
  input  logic          sys_rst,
  input  logic          en,
  output logic          hs_act_o,
  output logic          vs_act_o,
  output logic          act_o,
  output logic          frame_start_o,
  output logic [HW-1:0] x_o,
  output logic [VW-1:0] y_o,
  output logic [DW-1:0] frame_cnt_o
);

  localparam int HAS = HSP + HBP;
  localparam int VAS = VSP + VBP;

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [DW-1:0] frame_cnt_q, frame_cnt_d;

  // Advance the raster one pixel; disabled generator parks at the origin.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    frame_cnt_d = frame_cnt_q;
    if (!en) begin
      hcnt_d      = '0;
      vcnt_d      = '0;
      frame_cnt_d = '0;
    end else if (hcnt_q == HW'(HTOTAL - 1)) begin
      hcnt_d = '0;
      if (vcnt_q == VW'(VTOTAL - 1)) begin
        vcnt_d      = '0;
        frame_cnt_d = frame_cnt_q + 1'b1;
      end else begin
        vcnt_d = vcnt_q + 1'b1;
      end
    end else begin
      hcnt_d = hcnt_q + 1'b1;
    end
  end

  // Counter state register.
  always_ff @(posedge px_clk) begin
    // NOTE: state flops use non-blocking assignments so all update together at the edge.
    if (sys_rst) begin
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign hs_act_o      = hcnt_q < HW'(HSP);
  assign vs_act_o      = vcnt_q < VW'(VSP);
  assign act_o         = (hcnt_q >= HW'(HAS)) && (hcnt_q < HW'(HAS + HACT)) &&
                         (vcnt_q >= VW'(VAS)) && (vcnt_q < VW'(VAS + VACT));
  assign frame_start_o = (hcnt_q == '0) && (vcnt_q == '0);
  assign x_o           = hcnt_q - HW'(HAS);
  assign y_o           = vcnt_q - VW'(VAS);
  assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: rtl/tp_pattern_gen.sv
// Video timing and test-pattern generator: pattern select, pixel colour and output register.
module tp_pattern_gen
  import tp_pkg::*;
#(
  parameter int HACT     = VGA_HACT,
  parameter int HFP      = VGA_HFP,
  parameter int HSP      = VGA_HSP,
  parameter int HBP      = VGA_HBP,
  parameter int VACT     = VGA_VACT,
  parameter int VFP      = VGA_VFP,
  parameter int VSP      = VGA_VSP,
  parameter int VBP      = VGA_VBP,
  parameter int DW       = 8,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CHK_LOG2 = 5
) (
  input  logic              px_clk,
  input  logic              sys_rst,
  input  logic              en,
  input  logic [2:0]        mode_i,
  input  logic [3*DW-1:0]   solid_i,
  tp_pattern_gen_if.master  vid
);

  localparam int HW = $clog2(HSP + HBP + HACT + HFP);
  localparam int VW = $clog2(VSP + VBP + VACT + VFP);
  localparam int BW = HACT / 8;
  localparam int PW = $clog2(BW + 1);

  logic          hs_act, vs_act, act, frame_start;
  logic [HW-1:0] x;
  logic [VW-1:0] y;
  logic [DW-1:0] frame_cnt;

  tp_timing #(
    .HACT(HACT), .HFP(HFP), .HSP(HSP), .HBP(HBP),
    .VACT(VACT), .VFP(VFP), .VSP(VSP), .VBP(VBP), .DW(DW)
  ) u_timing (
    .px_clk        (px_clk),
    .sys_rst       (sys_rst),
    .en            (en),
    .hs_act_o      (hs_act),
    .vs_act_o      (vs_act),
    .act_o         (act),
    .frame_start_o (frame_start),
    .x_o           (x),
    .y_o           (y),
    .frame_cnt_o   (frame_cnt)
  );

  logic [2:0]      mode_q, mode_d;
  logic [3*DW-1:0] solid_q, solid_d;
  logic [2:0]      bar_idx_q, bar_idx_d, cur_idx;
  logic [PW-1:0]   bar_pix_q, bar_pix_d, cur_pix;
  logic [2:0]      bar_rgb;
  logic            chk;
  logic [DW-1:0]   ramp, moving, pix_r, pix_g, pix_b;
  logic            hsync_q, hsync_d, vsync_q, vsync_d;
  logic            dval_q, dval_d, sof_q, sof_d;
  logic [DW-1:0]   rdata_q, rdata_d, gdata_q, gdata_d, bdata_q, bdata_d;

  // Latch mode and solid colour at the frame origin so a frame never mixes patterns.
  always_comb begin
    mode_d  = mode_q;
    solid_d = solid_q;
    if (!en) begin
      mode_d  = SOLID;
      solid_d = '0;
    end else if (frame_start) begin
      mode_d  = mode_i;
      solid_d = solid_i;
    end
  end

  // Bar position: restart at x=0, step every BW pixels, last bar absorbs the remainder.
  always_comb begin
    cur_idx   = (x == '0) ? 3'd0 : bar_idx_q;
    cur_pix   = (x == '0) ? '0 : bar_pix_q;
    bar_idx_d = bar_idx_q;
    bar_pix_d = bar_pix_q;
    if (!en) begin
      bar_idx_d = '0;
      bar_pix_d = '0;
    end else if (act && (cur_idx != 3'd7)) begin
      if (cur_pix == PW'(BW - 1)) begin
        bar_idx_d = cur_idx + 3'd1;
        bar_pix_d = '0;
      end else begin
        bar_idx_d = cur_idx;
        bar_pix_d = cur_pix + 1'b1;
      end
    end
  end

  assign bar_rgb = BAR_RGB[cur_idx];
  assign chk     = 1'((x >> CHK_LOG2) ^ (y >> CHK_LOG2));
  assign ramp    = DW'(x);
  assign moving  = DW'(x) + frame_cnt;

  // Pixel colour for the latched pattern at the current raster position.
  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    case (mode_q)
      SOLID:   {pix_r, pix_g, pix_b} = solid_q;
      BARS: begin
        pix_r = {DW{bar_rgb[2]}};
        pix_g = {DW{bar_rgb[1]}};
        pix_b = {DW{bar_rgb[0]}};
      end
      HRAMP:   {pix_r, pix_g, pix_b} = {3{ramp}};
      CHECKER: {pix_r, pix_g, pix_b} = {3{{DW{chk}}}};
      MOVING:  {pix_r, pix_g, pix_b} = {3{moving}};
      default: ;
    endcase
  end

  // Next output values; idle levels whenever the generator is disabled.
  always_comb begin
    hsync_d = ~HS_POL;
    vsync_d = ~VS_POL;
    dval_d  = 1'b0;
    sof_d   = 1'b0;
    rdata_d = '0;
    gdata_d = '0;
    bdata_d = '0;
    if (en) begin
      hsync_d = hs_act ? HS_POL : ~HS_POL;
      vsync_d = vs_act ? VS_POL : ~VS_POL;
      dval_d  = act;
      sof_d   = act && (x == '0) && (y == '0);
      if (act) begin
        rdata_d = pix_r;
        gdata_d = pix_g;
        bdata_d = pix_b;
      end
    end
  end

  // Pattern state and output register stage.
  always_ff @(posedge px_clk) begin
    // NOTE: reset only control/output state; pure datapath could skip it, but here every flop is cheap and visible.
    if (sys_rst) begin
      mode_q    <= SOLID;
      solid_q   <= '0;
      bar_idx_q <= '0;
      bar_pix_q <= '0;
      hsync_q   <= ~HS_POL;
      vsync_q   <= ~VS_POL;
      dval_q    <= 1'b0;
      sof_q     <= 1'b0;
      rdata_q   <= '0;
      gdata_q   <= '0;
      bdata_q   <= '0;
    end else begin
      mode_q    <= mode_d;
      solid_q   <= solid_d;
      bar_idx_q <= bar_idx_d;
      bar_pix_q <= bar_pix_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      dval_q    <= dval_d;
      sof_q     <= sof_d;
      rdata_q   <= rdata_d;
      gdata_q   <= gdata_d;
      bdata_q   <= bdata_d;
    end
  end

  assign vid.hsync_o = hsync_q;
  assign vid.vsync_o = vsync_q;
  assign vid.dval_o  = dval_q;
  assign vid.sof_o   = sof_q;
  assign vid.rdata_o = rdata_q;
  assign vid.gdata_o = gdata_q;
  assign vid.bdata_o = bdata_q;

endmodule

// File: tb/tb_tp_pattern_gen.sv
// Directed bench for tp_pattern_gen on a 14x7 raster (8x4 active), checker squares of 2 pixels.
module tb_tp_pattern_gen;

  localparam int DW = 8;
  localparam logic [27:0] IDLE = 28'hC000000;  // hsync=1, vsync=1, rest 0

  localparam logic [23:0] BAR_TBL [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };
  localparam logic [7:0] CHK_ROW0 [8] = '{
    8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF
  };

  logic          px_clk = 1'b0;
  logic          sys_rst;
  logic          en;
  logic [2:0]    mode_i;
  logic [23:0]   solid_i;

  tp_pattern_gen_if #(.DW(DW)) vid ();

  tp_pattern_gen #(
    .HACT(8), .HFP(2), .HSP(2), .HBP(2),
    .VACT(4), .VFP(1), .VSP(1), .VBP(1),
    .DW(DW), .HS_POL(1'b0), .VS_POL(1'b0), .CHK_LOG2(1)
  ) dut (
    .px_clk  (px_clk),
    .sys_rst (sys_rst),
    .en      (en),
    .mode_i  (mode_i),
    .solid_i (solid_i),
    .vid     (vid)
  );

  always #5 px_clk = ~px_clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          c;
  logic [2:0]  lat_mode;
  logic [23:0] lat_solid;
  int          dval_cnt, sof_cnt, vs_low_cnt, hs_low_cnt, hs_fall_c, first_dv_c;
  logic        prev_hs;
  logic [7:0]  sof_pix [$];

  // Expected output vector for raster step cc under the latched pattern.
  function automatic logic [27:0] expect_vec(input int cc);
    int h, v, f, x, y;
    logic act;
    logic [23:0] pix;
    h   = cc % 14;
    v   = (cc / 14) % 7;
    f   = (cc / 98) % 256;
    act = (h >= 4) && (h < 12) && (v >= 2) && (v < 6);
    x   = h - 4;
    y   = v - 2;
    pix = 24'h0;
    if (act) begin
      case (lat_mode)
        3'd0:    pix = lat_solid;
        3'd1:    pix = BAR_TBL[x];
        3'd2:    pix = {3{8'(x)}};
        3'd3:    pix = {3{CHK_ROW0[x] ^ ((y >= 2) ? 8'hFF : 8'h00)}};
        3'd4:    pix = {3{8'(x + f)}};
        default: pix = 24'h0;
      endcase
    end
    return {(h < 2) ? 1'b0 : 1'b1, (v < 1) ? 1'b0 : 1'b1, act,
            act && (x == 0) && (y == 0), pix};
  endfunction

  function automatic logic [27:0] dut_vec();
    return {vid.hsync_o, vid.vsync_o, vid.dval_o, vid.sof_o,
            vid.rdata_o, vid.gdata_o, vid.bdata_o};
  endfunction

  task automatic step();
    @(posedge px_clk);
    #1;
  endtask

  task automatic clear_stats();
    dval_cnt   = 0;
    sof_cnt    = 0;
    vs_low_cnt = 0;
    hs_low_cnt = 0;
    hs_fall_c  = -1;
    first_dv_c = -1;
    prev_hs    = 1'b1;
  endtask

  // Run n raster steps comparing every output against the model.
  task automatic run(input string name, input int n);
    logic [27:0] got, want;
    for (int i = 0; i < n; i++) begin
      if ((c % 14 == 0) && ((c / 14) % 7 == 0)) begin
        lat_mode  = mode_i;
        lat_solid = solid_i;
      end
      step();
      got  = dut_vec();
      want = expect_vec(c);
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL %s step=%0d got=%h exp=%h", name, c, got, want);
      end
      if (vid.dval_o === 1'b1) dval_cnt++;
      if (vid.sof_o === 1'b1) begin
        sof_cnt++;
        sof_pix.push_back(vid.rdata_o);
      end
      if (vid.vsync_o === 1'b0) vs_low_cnt++;
      if (vid.hsync_o === 1'b0) hs_low_cnt++;
      if (prev_hs && (vid.hsync_o === 1'b0) && (first_dv_c < 0)) hs_fall_c = c;
      if ((vid.dval_o === 1'b1) && (first_dv_c < 0)) first_dv_c = c;
      prev_hs = vid.hsync_o;
      c++;
    end
  endtask

  task automatic check_idle(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      n_cmp++;
      if (dut_vec() !== IDLE) begin
        n_err++;
        $display("FAIL %s cycle=%0d got=%h exp=%h", name, i, dut_vec(), IDLE);
      end
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    en      = 1'b0;
    mode_i  = 3'd0;
    solid_i = 24'h0;
    check_idle("reset", 3);
  endtask

  task automatic test_solid();
    mode_i  = 3'd0;
    solid_i = 24'h123456;
    sys_rst = 1'b0;
    en      = 1'b1;
    c       = 0;
    clear_stats();
    run("solid", 98);
    check_int("solid_dval_per_frame", dval_cnt, 32);
    check_int("solid_sof_per_frame", sof_cnt, 1);
    check_int("solid_vsync_low", vs_low_cnt, 14);
    check_int("solid_hsync_low", hs_low_cnt, 14);
    check_int("solid_hs_to_dval", first_dv_c - hs_fall_c, 4);
  endtask

  task automatic test_patterns();
    mode_i = 3'd1;
    run("bars", 98);
    mode_i = 3'd3;
    run("checker", 98);
    mode_i = 3'd2;
    run("hramp", 98);
    mode_i = 3'd6;
    run("reserved", 98);
  endtask

  task automatic test_moving();
    sys_rst = 1'b1;
    check_idle("moving_rst", 2);
    sys_rst = 1'b0;
    mode_i  = 3'd4;
    c       = 0;
    sof_pix.delete();
    clear_stats();
    run("moving", 2 * 98 + 50);
    mode_i = 3'd0;
    run("moving_hold", 48);
    run("moving_to_solid", 98);
    check_int("moving_sof_count", sof_pix.size(), 4);
    if (sof_pix.size() == 4) begin
      check_int("moving_f0_px0", sof_pix[0], 8'h00);
      check_int("moving_f1_px0", sof_pix[1], 8'h01);
      check_int("moving_f2_px0", sof_pix[2], 8'h02);
      check_int("moving_f3_solid", sof_pix[3], 8'h12);
    end
  endtask

  task automatic test_en_abort();
    run("pre_abort", 98 + 35);
    en = 1'b0;
    check_idle("en_off", 4);
    en = 1'b1;
    c  = 0;
    clear_stats();
    run("en_restart", 98);
    check_int("en_restart_dval", dval_cnt, 32);
    check_int("en_restart_hs_to_dval", first_dv_c - hs_fall_c, 4);
  endtask

  task automatic test_rst_priority();
    run("pre_rst", 40);
    sys_rst = 1'b1;
    check_idle("rst_over_en", 3);
    sys_rst = 1'b0;
    c = 0;
    clear_stats();
    run("rst_restart", 98);
    check_int("rst_restart_dval", dval_cnt, 32);
    check_int("rst_restart_sof", sof_cnt, 1);
  endtask

  initial begin
    sys_rst = 1'b1;
    en      = 1'b0;
    mode_i  = 3'd0;
    solid_i = 24'h0;
    test_reset();
    test_solid();
    test_patterns();
    test_moving();
    test_en_abort();
    test_rst_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tp_pattern_gen.md
# tp_pattern_gen

Parametrised video timing and test-pattern generator for the pixel-clock domain. It produces hsync/vsync/data-valid for any raster geometry and drives RGB data from a run-time selectable pattern: solid colour, colour bars, ramp, checkerboard or moving ramp. It sits at the head of the video pipeline, feeding display and capture paths during bring-up and self-test.

## Interface
Parameters:
- HACT, 640, active pixels per line
- HFP, 16, horizontal front porch (clocks)
- HSP, 96, hsync pulse width (clocks)
- HBP, 48, horizontal back porch (clocks)
- VACT, 480, active lines per frame
- VFP, 10, vertical front porch (lines)
- VSP, 2, vsync pulse width (lines)
- VBP, 33, vertical back porch (lines)
- DW, 8, bits per colour channel
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- CHK_LOG2, 5, checkerboard square size = 2^CHK_LOG2 pixels

Ports:
- px_clk  in  1  pixel clock; all logic on rising edge
- sys_rst  in  1  reset; synchronous, active-high
- en  in  1  generator enable
- mode_i  in  3  pattern select (tp_mode_t)
- solid_i  in  3*DW  solid colour {R,G,B}
- vsync_o  out  1  vertical sync, polarity VS_POL
- hsync_o  out  1  horizontal sync, polarity HS_POL
- dval_o  out  1  high on active pixels only
- sof_o  out  1  one-cycle pulse with first active pixel of a frame
- rdata_o / gdata_o / bdata_o  out  DW each  pixel data; 0 when dval_o low

## Operation
- Line order: sync, back porch, active, front porch. HTOTAL = HSP+HBP+HACT+HFP; VTOTAL = VSP+VBP+VACT+VFP.
- hcnt 0..HTOTAL-1, wraps to 0; vcnt increments on hcnt wrap, 0..VTOTAL-1, wraps to 0.
- hsync active while hcnt < HSP; vsync active while vcnt < VSP (whole lines).
- Active region: HSP+HBP <= hcnt < HSP+HBP+HACT and VSP+VBP <= vcnt < VSP+VBP+VACT. x = hcnt-(HSP+HBP), y = vcnt-(VSP+VBP).
- mode_i and solid_i are sampled at hcnt=0, vcnt=0 and held for the whole frame; mid-frame changes take effect next frame.
- Patterns (max = all ones, DW bits):
  - SOLID (0): solid_i.
  - BARS (1): 8 equal bars, width HACT/8 (integer; remainder pixels extend the last bar). Order: white, yellow, cyan, green, magenta, red, blue, black. Bar index tracked by counter, no divider.
  - HRAMP (2): R=G=B = x[DW-1:0] (wraps mod 2^DW).
  - CHECKER (3): white if x[CHK_LOG2] XOR y[CHK_LOG2], else black.
  - MOVING (4): R=G=B = (x + frame_cnt)[DW-1:0]; frame_cnt is DW-bit, increments at each vcnt wrap, wraps mod 2^DW.
  - 5-7: reserved, output black while dval_o high.
- en low: counters, frame_cnt and outputs held at reset values. Deassert mid-frame aborts immediately. On en rising, generation starts at hcnt=0, vcnt=0.
- Reset values: hsync_o = ~HS_POL, vsync_o = ~VS_POL, dval_o=0, sof_o=0, data=0, counters=0, frame_cnt=0, latched mode=SOLID.

## Timing
- All outputs registered; every output lags its counter state by exactly 1 cycle, and all outputs stay mutually aligned.
- First hsync_o active: cycle after reset release with en high.
- sof_o coincides with the first dval_o of frame (x=0, y=0).
- dval_o high for exactly HACT consecutive cycles per active line; VACT such lines per frame.
- Frame period exactly HTOTAL*VTOTAL cycles; no gaps at wrap.
- sys_rst has priority over en.

## Structure
- Package tp_pkg: tp_mode_t enum (SOLID, BARS, HRAMP, CHECKER, MOVING), bar colour constant table, VGA 640x480 default timing constants.
- Sub-module tp_timing: counters, sync/active decode, x/y, frame_cnt. The top level adds pattern generation and the output register stage.

## Test plan
Small geometry for all scenarios: HACT=8, HSP=2, HBP=2, HFP=2, VACT=4, VSP=1, VBP=1, VFP=1, DW=8 (HTOTAL=14, VTOTAL=7).
- Reset, then en=1 -> hsync_o low 2 of every 14 cycles; vsync_o low for the first 14 cycles of each 98-cycle frame; dval_o first rises 4 cycles after the hsync_o fall, with sof_o high on that cycle.
- SOLID, solid_i=0x123456 -> every active pixel R=0x12, G=0x34, B=0x56; data 0 outside active; 32 dval cycles per frame.
- BARS -> pixels 0..7 = FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- MOVING over 3 frames -> line pixel 0 = 0x00, 0x01, 0x02; change mode_i to SOLID mid-frame -> no effect until the next frame start.
- CHECKER, CHK_LOG2=1 -> y=0 row: 00,00,FF,FF,00,00,FF,FF; y=2 row inverted.
- en dropped mid-line, sys_rst asserted with en high -> outputs return to reset values on the next cycle; restart is identical to the first frame.
